// File: rtl/seq_game_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_game_if
// Brief    : Control/status bundle for the seq_game memory game.
// Revision : 1.0
// ============================================================================
interface seq_game_if;
    logic       start;
    logic [7:0] rand_in;
    logic [3:0] btn;
    logic [3:0] led;
    logic [4:0] level;
    logic       busy;
    logic       win;
    logic       fail;

    modport master (
        output start, rand_in, btn,
        input  led, level, busy, win, fail
    );

    modport slave (
        input  start, rand_in, btn,
        output led, level, busy, win, fail
    );
endinterface
`default_nettype wire

// File: rtl/seq_game.sv
`default_nettype none
// ============================================================================
// Module   : seq_game
// Brief    : Simon-style memory game: grows a random 2-bit symbol pattern,
//            plays it on a one-hot LED display and checks the player's presses.
// Revision : 1.0
// ============================================================================
module seq_game #(
    parameter int MAX_LEN     = 16,
    parameter int STEP_CYCLES = 4,
    parameter int TIMEOUT     = 255
) (
    input  wire       clk,
    input  wire       rst_n,
    seq_game_if.slave bus
);

    localparam int c_idx_w = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int c_ph_w  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int c_to_w  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [c_ph_w-1:0] c_ph_last = c_ph_w'(STEP_CYCLES - 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);
    localparam logic [4:0]        c_max_len = 5'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADD      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_INPUT    = 3'd4,
        S_WIN      = 3'd5,
        S_FAIL     = 3'd6
    } state_t;

    state_t              r_state;
    logic [1:0]          r_seq [MAX_LEN];
    logic [4:0]          r_len;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_ph_w-1:0]   r_phase;
    logic [c_to_w-1:0]   r_tmo;
    logic [3:0]          r_btn_q;
    logic [3:0]          r_led;
    logic                r_busy;
    logic                r_win;
    logic                r_fail;

    logic [3:0]          w_press;
    logic [3:0]          w_expect;
    logic [c_idx_w-1:0]  w_idx_inc;
    logic                w_last;
    logic                w_onehot;
    logic [1:0]          w_first_sym;
    logic                w_unused;

    always_comb begin
        w_press     = bus.btn & ~r_btn_q;
        w_expect    = 4'b0001 << r_seq[r_idx];
        w_idx_inc   = r_idx + c_idx_w'(1);
        w_last      = (5'(r_idx) == (r_len - 5'd1));
        w_onehot    = (w_press != 4'd0) && ((w_press & (w_press - 4'd1)) == 4'd0);
        // The symbol being appended is the first one shown when the pattern was empty.
        w_first_sym = (r_len == 5'd0) ? bus.rand_in[1:0] : r_seq[0];
    end

    assign w_unused = &{1'b0, bus.rand_in[7:2]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_len   <= 5'd0;
            r_idx   <= '0;
            r_phase <= '0;
            r_tmo   <= '0;
            r_btn_q <= 4'd0;
            r_led   <= 4'd0;
            r_busy  <= 1'b0;
            r_win   <= 1'b0;
            r_fail  <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seq[i] <= 2'd0;
            end
        end else begin
            r_btn_q <= bus.btn;
            case (r_state)
                S_IDLE, S_WIN, S_FAIL: begin
                    if (bus.start) begin
                        r_state <= S_ADD;
                        r_len   <= 5'd0;
                        r_win   <= 1'b0;
                        r_fail  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_led   <= 4'd0;
                    end
                end
                S_ADD: begin
                    r_seq[r_len[c_idx_w-1:0]] <= bus.rand_in[1:0];
                    r_len   <= r_len + 5'd1;
                    r_idx   <= '0;
                    r_phase <= '0;
                    r_state <= S_SHOW_ON;
                    r_led   <= 4'b0001 << w_first_sym;
                end
                S_SHOW_ON: begin
                    if (r_phase == c_ph_last) begin
                        r_phase <= '0;
                        r_state <= S_SHOW_OFF;
                        r_led   <= 4'd0;
                    end else begin
                        r_phase <= r_phase + c_ph_w'(1);
                    end
                end
                S_SHOW_OFF: begin
                    if (r_phase == c_ph_last) begin
                        r_phase <= '0;
                        if (w_last) begin
                            r_state <= S_INPUT;
                            r_idx   <= '0;
                            r_tmo   <= '0;
                            r_led   <= bus.btn;
                        end else begin
                            r_state <= S_SHOW_ON;
                            r_idx   <= w_idx_inc;
                            r_led   <= 4'b0001 << r_seq[w_idx_inc];
                        end
                    end else begin
                        r_phase <= r_phase + c_ph_w'(1);
                    end
                end
                S_INPUT: begin
                    r_led <= bus.btn;
                    if (w_press == 4'd0) begin
                        if (r_tmo == c_to_last) begin
                            r_state <= S_FAIL;
                            r_fail  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_led   <= 4'd0;
                        end else begin
                            r_tmo <= r_tmo + c_to_w'(1);
                        end
                    end else if (w_onehot && (w_press == w_expect)) begin
                        if (!w_last) begin
                            r_idx <= w_idx_inc;
                            r_tmo <= '0;
                        end else if (r_len == c_max_len) begin
                            r_state <= S_WIN;
                            r_win   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_led   <= 4'hF;
                        end else begin
                            r_state <= S_ADD;
                            r_led   <= 4'd0;
                        end
                    end else begin
                        r_state <= S_FAIL;
                        r_fail  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_led   <= 4'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_led   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.led   = r_led;
    assign bus.level = r_len;
    assign bus.busy  = r_busy;
    assign bus.win   = r_win;
    assign bus.fail  = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_seq_game.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_game
// Brief    : Randomized bench for seq_game against a behavioural game model,
//            two instances (default sizing and a short MAX_LEN/TIMEOUT build).
// Revision : 1.0
// ============================================================================
module tb_seq_game;

    localparam int A_MAX = 16, A_STEP = 4, A_TO = 255;
    localparam int B_MAX = 2,  B_STEP = 4, B_TO = 10;

    localparam int ST_IDLE = 0, ST_ADD = 1, ST_ON = 2, ST_OFF = 3,
                   ST_INPUT = 4, ST_WIN = 5, ST_FAIL = 6;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic [7:0] rand_in = 8'h00;
    logic [3:0] btn     = 4'h0;
    logic       chk_en  = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    seq_game_if ifa ();
    seq_game_if ifb ();

    assign ifa.start = start;  assign ifa.rand_in = rand_in;  assign ifa.btn = btn;
    assign ifb.start = start;  assign ifb.rand_in = rand_in;  assign ifb.btn = btn;

    seq_game #(.MAX_LEN(A_MAX), .STEP_CYCLES(A_STEP), .TIMEOUT(A_TO)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    seq_game #(.MAX_LEN(B_MAX), .STEP_CYCLES(B_STEP), .TIMEOUT(B_TO)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    // Game model: one entry per instance.
    int         m_st  [2];
    int         m_len [2];
    int         m_idx [2];
    int         m_cyc [2];
    int         m_tmo [2];
    int         m_seq [2][32];
    logic [3:0] m_btnq [2];

    logic [3:0] pat28 [4];

    function automatic int pmax(int k);
        return (k == 0) ? A_MAX : B_MAX;
    endfunction
    function automatic int pstep(int k);
        return (k == 0) ? A_STEP : B_STEP;
    endfunction
    function automatic int pto(int k);
        return (k == 0) ? A_TO : B_TO;
    endfunction

    task automatic model_step(int k, logic r, logic s, logic [7:0] ri, logic [3:0] b);
        logic [3:0] press;
        if (!r) begin
            m_st[k] = ST_IDLE; m_len[k] = 0; m_idx[k] = 0; m_cyc[k] = 0; m_tmo[k] = 0;
            m_btnq[k] = 4'h0;
            for (int i = 0; i < 32; i++) m_seq[k][i] = 0;
            return;
        end
        press     = b & ~m_btnq[k];
        m_btnq[k] = b;
        case (m_st[k])
            ST_IDLE, ST_WIN, ST_FAIL: if (s) begin m_len[k] = 0; m_st[k] = ST_ADD; end
            ST_ADD: begin
                m_seq[k][m_len[k]] = int'(ri[1:0]);
                m_len[k]++; m_idx[k] = 0; m_cyc[k] = 0; m_st[k] = ST_ON;
            end
            ST_ON: begin
                m_cyc[k]++;
                if (m_cyc[k] == pstep(k)) begin m_cyc[k] = 0; m_st[k] = ST_OFF; end
            end
            ST_OFF: begin
                m_cyc[k]++;
                if (m_cyc[k] == pstep(k)) begin
                    m_cyc[k] = 0;
                    if (m_idx[k] == m_len[k] - 1) begin
                        m_st[k] = ST_INPUT; m_idx[k] = 0; m_tmo[k] = 0;
                    end else begin
                        m_idx[k]++; m_st[k] = ST_ON;
                    end
                end
            end
            ST_INPUT: begin
                if (press == 4'h0) begin
                    m_tmo[k]++;
                    if (m_tmo[k] >= pto(k)) m_st[k] = ST_FAIL;
                end else if ($countones(press) == 1 && press == 4'(1 << m_seq[k][m_idx[k]])) begin
                    if (m_idx[k] < m_len[k] - 1) begin m_idx[k]++; m_tmo[k] = 0; end
                    else m_st[k] = (m_len[k] == pmax(k)) ? ST_WIN : ST_ADD;
                end else begin
                    m_st[k] = ST_FAIL;
                end
            end
            default: m_st[k] = ST_IDLE;
        endcase
    endtask

    function automatic logic [3:0] exp_led(int k);
        case (m_st[k])
            ST_ON:    return 4'(1 << m_seq[k][m_idx[k]]);
            ST_INPUT: return m_btnq[k];
            ST_WIN:   return 4'hF;
            default:  return 4'h0;
        endcase
    endfunction

    function automatic logic exp_busy(int k);
        return (m_st[k] >= ST_ADD) && (m_st[k] <= ST_INPUT);
    endfunction

    task automatic chkv(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
    endtask

    // Every-cycle comparison of both instances against the model.
    initial begin : monitor
        logic       s_r, s_s;
        logic [7:0] s_ri;
        logic [3:0] s_b;
        forever begin
            @(posedge clk);
            s_r = rst_n; s_s = start; s_ri = rand_in; s_b = btn;
            #1;
            model_step(0, s_r, s_s, s_ri, s_b);
            model_step(1, s_r, s_s, s_ri, s_b);
            if (chk_en) begin
                chkv("a.led",   32'(ifa.led),   32'(exp_led(0)));
                chkv("a.level", 32'(ifa.level), 32'(m_len[0]));
                chkv("a.busy",  32'(ifa.busy),  32'(exp_busy(0)));
                chkv("a.win",   32'(ifa.win),   32'(m_st[0] == ST_WIN));
                chkv("a.fail",  32'(ifa.fail),  32'(m_st[0] == ST_FAIL));
                chkv("b.led",   32'(ifb.led),   32'(exp_led(1)));
                chkv("b.level", 32'(ifb.level), 32'(m_len[1]));
                chkv("b.busy",  32'(ifb.busy),  32'(exp_busy(1)));
                chkv("b.win",   32'(ifb.win),   32'(m_st[1] == ST_WIN));
                chkv("b.fail",  32'(ifb.fail),  32'(m_st[1] == ST_FAIL));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reset_both();
        rst_n = 1'b0; start = 1'b0; btn = 4'h0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_st(int k, int st, int bound);
        int n = 0;
        while (m_st[k] != st && n < bound) begin tick(); n++; end
        n_chk++;
        if (m_st[k] == st) n_pass++;
        else $display("FAIL wait_st dut%0d: state %0d after %0d cycles, required %0d", k, m_st[k], n, st);
    endtask

    // Plays the model's pattern back; returns right after the last press edge.
    task automatic press_seq(int k);
        int n = m_len[k];
        for (int i = 0; i < n; i++) begin
            btn = 4'(1 << m_seq[k][i]);
            tick();
            btn = 4'h0;
            if (i != n - 1) tick();
        end
    endtask

    task automatic drive_random(int k);
        int r;
        rand_in = 8'($urandom);
        rst_n   = ($urandom_range(0, 1999) != 0);
        if (m_st[k] == ST_IDLE || m_st[k] == ST_WIN || m_st[k] == ST_FAIL)
            start = ($urandom_range(0, 3) == 0);
        else
            start = ($urandom_range(0, 15) == 0);
        if (m_st[k] == ST_INPUT) begin
            if (btn != 4'h0) begin
                btn = 4'h0;
            end else begin
                r = $urandom_range(0, 99);
                if (r < 70)      btn = 4'(1 << m_seq[k][m_idx[k]]);
                else if (r < 75) btn = 4'($urandom);
                else             btn = 4'h0;
            end
        end else begin
            btn = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
        end
    endtask

    initial begin : driver
        pat28 = '{4'b0100, 4'b0000, 4'b1000, 4'b0000};
        tick(); tick(); tick();
        chk_en = 1'b1;
        chkv("reset.led",   32'(ifa.led),   32'h0);
        chkv("reset.level", 32'(ifa.level), 32'h0);
        chkv("reset.busy",  32'(ifa.busy),  32'h0);
        rst_n = 1'b1;

        // First round: symbol 2.
        start = 1'b1; rand_in = 8'h02; tick();
        start = 1'b0;
        chkv("r27.busy_add",  32'(ifa.busy),  32'h1);
        chkv("r27.level_add", 32'(ifa.level), 32'h0);
        tick();
        chkv("r27.level", 32'(ifa.level), 32'h1);
        for (int i = 0; i < 8; i++) begin
            chkv("r27.led", 32'(ifa.led), (i < 4) ? 32'h4 : 32'h0);
            tick();
        end
        chkv("r27.busy_input", 32'(ifa.busy), 32'h1);
        chkv("r27.led_input",  32'(ifa.led),  32'h0);

        // Correct press, second symbol 3.
        btn = 4'b0100; rand_in = 8'h07; tick();
        chkv("r28.busy_add", 32'(ifa.busy), 32'h1);
        chkv("r28.led_add",  32'(ifa.led),  32'h0);
        btn = 4'h0; tick();
        chkv("r28.level", 32'(ifa.level), 32'h2);
        for (int i = 0; i < 16; i++) begin
            chkv("r28.play", 32'(ifa.led), 32'(pat28[i / 4]));
            tick();
        end

        // Wrong press on the second symbol.
        btn = 4'b0100; tick();
        btn = 4'h0;    tick();
        btn = 4'b0001; tick();
        chkv("r29.fail", 32'(ifa.fail), 32'h1);
        chkv("r29.busy", 32'(ifa.busy), 32'h0);
        chkv("r29.led",  32'(ifa.led),  32'h0);
        btn = 4'h0; start = 1'b1; tick();
        start = 1'b0;
        chkv("r29.fail_clr",  32'(ifa.fail),  32'h0);
        chkv("r29.level_add", 32'(ifa.level), 32'h0);
        tick();
        chkv("r29.level", 32'(ifa.level), 32'h1);

        // Short build: two correct rounds win.
        reset_both();
        start = 1'b1; rand_in = 8'h01; tick();
        start = 1'b0; tick();
        rand_in = 8'h03;
        wait_st(1, ST_INPUT, 100);
        press_seq(1);
        tick();
        chkv("r30.led_play", 32'(ifb.led),   32'h2);
        chkv("r30.level2",   32'(ifb.level), 32'h2);
        wait_st(1, ST_INPUT, 100);
        press_seq(1);
        chkv("r30.win",   32'(ifb.win),   32'h1);
        chkv("r30.led",   32'(ifb.led),   32'hF);
        chkv("r30.level", 32'(ifb.level), 32'h2);
        chkv("r30.busy",  32'(ifb.busy),  32'h0);

        // Button held across entry into INPUT is not a press.
        btn = 4'b0001; start = 1'b1; rand_in = 8'h00; tick();
        start = 1'b0;
        wait_st(1, ST_INPUT, 100);
        chkv("r31.held_led", 32'(ifb.led), 32'h1);
        tick(); tick();
        chkv("r31.held_level", 32'(ifb.level), 32'h1);
        chkv("r31.held_busy",  32'(ifb.busy),  32'h1);
        btn = 4'h0; tick();
        btn = 4'b0001; tick();
        chkv("r31.repress_level", 32'(ifb.level), 32'h1);
        chkv("r31.repress_led",   32'(ifb.led),   32'h0);
        btn = 4'h0; tick();
        chkv("r31.level2", 32'(ifb.level), 32'h2);

        // Idle timeout.
        wait_st(1, ST_INPUT, 100);
        for (int i = 1; i < 10; i++) begin
            tick();
            chkv("r31.no_fail", 32'(ifb.fail), 32'h0);
        end
        tick();
        chkv("r31.timeout",      32'(ifb.fail), 32'h1);
        chkv("r31.timeout_busy", 32'(ifb.busy), 32'h0);

        // Reset during playback of a length-3 pattern.
        reset_both();
        start = 1'b1; rand_in = 8'($urandom); tick();
        start = 1'b0;
        wait_st(0, ST_INPUT, 100);
        press_seq(0);
        wait_st(0, ST_INPUT, 200);
        press_seq(0);
        tick();
        chkv("r32.level3", 32'(ifa.level), 32'h3);
        tick();
        rst_n = 1'b0; tick();
        chkv("r32.level", 32'(ifa.level), 32'h0);
        chkv("r32.led",   32'(ifa.led),   32'h0);
        chkv("r32.busy",  32'(ifa.busy),  32'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4000; c++) begin
                drive_random(k);
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_game.md
SEQ_GAME -- requirements
Module: seq_game

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning the maximum pattern length in symbols (2..31).
REQ-002 SHALL have parameter STEP_CYCLES, default 4, meaning the clock cycles each playback LED-on phase and each LED-off phase lasts (>=1).
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum idle cycles allowed per expected press (>=1).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port start  input  1  level; begins a game.
REQ-007 SHALL have port rand_in  input  8  pseudo-random byte from the upstream 8-bit LFSR output.
REQ-008 SHALL have port btn  input  4  player buttons, synchronized, active-high levels.
REQ-009 SHALL have port led  output  4  one-hot playback display.
REQ-010 SHALL have port level  output  5  current pattern length.
REQ-011 SHALL have ports busy, win and fail  output  1 each  game status flags.

Function
REQ-012 SHALL keep the pattern in a MAX_LEN x 2-bit store seq[], a length counter len, a position index idx, a phase counter and a timeout counter.
REQ-013 SHALL implement states IDLE, ADD, SHOW_ON, SHOW_OFF, INPUT, WIN and FAIL.
REQ-014 SHALL, in IDLE, WIN or FAIL with start=1, clear len, win and fail and enter ADD on the next cycle; start SHALL be ignored in all other states.
REQ-015 SHALL, in ADD (exactly 1 cycle), write seq[len]<=rand_in[1:0], set len<=len+1 and idx<=0, clear the phase counter, then enter SHOW_ON.
REQ-016 SHALL, in SHOW_ON, drive led = 1<<seq[idx] for exactly STEP_CYCLES cycles, then enter SHOW_OFF.
REQ-017 SHALL, in SHOW_OFF, drive led=0 for exactly STEP_CYCLES cycles, then:
- if idx==len-1: enter INPUT with idx<=0 and the timeout counter cleared;
- otherwise: set idx<=idx+1 and return to SHOW_ON.
REQ-018 SHALL derive press = btn & ~btn_q, where btn_q is btn registered every cycle, in every state.
REQ-019 SHALL, in INPUT, drive led = btn and evaluate press each cycle:
- press==0: increment the timeout counter; on reaching TIMEOUT, enter FAIL;
- press one-hot and equal to 1<<seq[idx] with idx<len-1: set idx<=idx+1 and clear the timeout counter;
- matching press with idx==len-1: enter WIN if len==MAX_LEN, else ADD;
- non-matching or multi-bit press: enter FAIL.
REQ-020 SHALL, in WIN, drive win=1 and led=4'hF; in FAIL, drive fail=1 and led=4'h0; both SHALL hold until start.
REQ-021 SHALL drive busy=1 exactly in ADD, SHOW_ON, SHOW_OFF and INPUT.
REQ-022 SHALL drive level=len at all times, with len never exceeding MAX_LEN.
REQ-023 SHALL register all outputs; the state-dependent outputs SHALL be valid in the same cycle the state is entered.
REQ-024 SHALL ignore button presses outside INPUT (btn_q still updates).

Reset
REQ-025 SHALL, when rst_n=0 at a clock edge, enter IDLE, clear len, idx, all counters, btn_q and every seq[] entry, and drive led=0, level=0, busy=0, win=0 and fail=0, overriding every other input including start.
REQ-026 SHALL abandon any game in progress when reset is asserted mid-operation, with no residual pattern retained.

Verification
REQ-027 SHALL pass: reset, then start=1 for 1 cycle with rand_in=8'h02 -> ADD stores 2, level=1, led=4'b0100 for 4 cycles then 0 for 4 cycles, then INPUT with busy=1.
REQ-028 SHALL pass: in INPUT, btn 0->4'b0100 -> ADD; rand_in=8'h07 -> seq={2,3}, level=2, playback led 0100,0000,1000,0000 with 4 cycles each.
REQ-029 SHALL pass: in INPUT expecting symbol 3, a press of btn=4'b0001 -> FAIL next cycle, fail=1, busy=0, led=0; start then re-enters ADD with level=1.
REQ-030 SHALL pass: with MAX_LEN=2 and correct presses for both rounds -> WIN, win=1, led=4'hF, level=2.
REQ-031 SHALL pass: with TIMEOUT=10 and no press in INPUT -> FAIL exactly 10 cycles after entering INPUT; btn held high across entry into INPUT -> no press registered until it is released and pressed again.
REQ-032 SHALL pass: rst_n=0 during SHOW_ON with level=3 -> next cycle IDLE, level=0, led=0, busy=0.
